// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizer, debouncer and short/long/repeat press classifier.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    logic [1:0]        sync;
    logic              btn_s;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_nxt;
    logic              toggle;
    logic              rise;
    logic              fall;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_hit;
    logic              rep_hit;
    state_t            state;
    state_t            state_nxt;
    logic              press_d;
    logic              short_d;
    logic              long_d;
    logic              repeat_d;

    // Two-flop synchronizer on the raw active-low input; reset value reads as released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], btn_n};
        end
    end

    assign btn_s = ~sync[1];

    // Debounce: count consecutive disagreeing cycles, flip the level after DEBOUNCE_CYCLES of them.
    always_comb begin
        toggle = 1'b0;
        db_nxt = '0;
        if (btn_s != btn_level) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                toggle = 1'b1;
            end else begin
                db_nxt = db_cnt + DB_W'(1);
            end
        end
    end

    assign rise     = toggle & ~btn_level;
    assign fall     = toggle & btn_level;
    assign hold_hit = (hold_cnt == HOLD_W'(LONG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else begin
            db_cnt    <= db_nxt;
            btn_level <= btn_level ^ toggle;
        end
    end

    // Hold counter is zero whenever not in HELD, so it starts from 0 on entry; saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state != HELD) begin
            hold_cnt <= '0;
        end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RP_W = $clog2(REPEAT_CYCLES + 1);

    logic [RP_W-1:0] rep_cnt;
    logic            rep_wrap;

    assign rep_wrap = (rep_cnt == RP_W'(REPEAT_CYCLES - 1));
    assign rep_hit  = (state == LONG) && !fall && rep_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
        end else if ((state != LONG) || rep_wrap) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + RP_W'(1);
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a release in the threshold cycle takes priority over going long.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rise) state_nxt = HELD;
            HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                end else if (hold_hit) begin
                    state_nxt = LONG;
                end
            end
            LONG: if (fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pulse decode, registered below so each strobe lines up with the edge that causes it.
    always_comb begin
        press_d  = 1'b0;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state)
            IDLE: press_d = rise;
            HELD: begin
                short_d = fall;
                long_d  = !fall && hold_hit;
            end
            LONG: repeat_d = rep_hit;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_pulse  <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            press_pulse  <= press_d;
            short_pulse  <= short_d;
            long_pulse   <= long_d;
            repeat_pulse <= repeat_d;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short sim thresholds (4/20/8).
// Repeat expectations follow BTN_AUTOREPEAT_EN when it is defined for the build.
module tb_btn_conditioner;

    localparam int DB = 4;
    localparam int LG = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn_n;
    logic btn_level;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .btn_level   (btn_level),
        .press_pulse (press_pulse),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: history of pressed samples; level flips once the synchronized
    // view (2 edges late) has disagreed with it for DB consecutive edges.
    logic hist [64];
    int   cyc      = 0;
    int   edge_no  = 0;
    int   press_at = 0;
    int   held     = 0;
    logic all_diff = 1'b0;
    logic m_level  = 1'b0;
    logic e_press  = 1'b0;
    logic e_short  = 1'b0;
    logic e_long   = 1'b0;
    logic e_rep    = 1'b0;

    function automatic logic pressed_at(input int k);
        return (k <= 0) ? 1'b0 : hist[k % 64];
    endfunction

    always @(posedge clk) begin
        edge_no++;
        e_press = 1'b0;
        e_short = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (rst) begin
            cyc     = 0;
            m_level = 1'b0;
            for (int i = 0; i < 64; i++) hist[i] = 1'b0;
        end else begin
            cyc++;
            hist[cyc % 64] = ~btn_n;
            all_diff = 1'b1;
            for (int k = cyc - DB - 1; k <= cyc - 2; k++) begin
                if (pressed_at(k) == m_level) all_diff = 1'b0;
            end
            if (all_diff && !m_level) begin
                m_level  = 1'b1;
                press_at = cyc;
                e_press  = 1'b1;
            end else if (all_diff && m_level) begin
                m_level = 1'b0;
                e_short = ((cyc - press_at) <= LG);
            end else if (m_level) begin
                held   = cyc - press_at;
                e_long = (held == LG);
`ifdef BTN_AUTOREPEAT_EN
                e_rep  = (held > LG) && (((held - LG) % RP) == 0);
`endif
            end
        end
    end

    // Per-cycle comparison and pulse bookkeeping for the scenario checks.
    int n_press = 0, n_short = 0, n_long = 0, n_rep = 0;
    int t_press = -1, t_long = -1, t_rep = -1;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_outputs",
                  int'({btn_level, press_pulse, short_pulse, long_pulse, repeat_pulse}), 0);
        end else begin
            check("btn_level",    int'(btn_level),    int'(m_level));
            check("press_pulse",  int'(press_pulse),  int'(e_press));
            check("short_pulse",  int'(short_pulse),  int'(e_short));
            check("long_pulse",   int'(long_pulse),   int'(e_long));
            check("repeat_pulse", int'(repeat_pulse), int'(e_rep));
            if (press_pulse) begin n_press++; t_press = edge_no; end
            if (short_pulse) n_short++;
            if (long_pulse) begin n_long++; t_long = edge_no; end
            if (repeat_pulse) begin
                n_rep++;
                if (t_rep < 0) t_rep = edge_no;
            end
        end
        check("one_pulse_max",
              int'((int'(press_pulse) + int'(short_pulse) + int'(long_pulse) + int'(repeat_pulse)) <= 1), 1);
    end

    task automatic clear_counts();
        n_press = 0; n_short = 0; n_long = 0; n_rep = 0;
        t_press = -1; t_long = -1; t_rep = -1;
    endtask

    // Hold btn_n low for exactly `low` sampled edges, then release and let things settle.
    task automatic press_for(input int low);
        clear_counts();
        btn_n = 1'b0;
        repeat (low) @(posedge clk);
        #3;
        btn_n = 1'b1;
        repeat (30) @(posedge clk);
        #3;
    endtask

    task automatic expect_counts(input string tag, input int p, input int s, input int l, input int r);
        check({tag, "_press_cnt"},  n_press, p);
        check({tag, "_short_cnt"},  n_short, s);
        check({tag, "_long_cnt"},   n_long, l);
        check({tag, "_repeat_cnt"}, n_rep, r);
        check({tag, "_level_after"}, int'(btn_level), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        rst   = 1'b1;
        btn_n = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("reset_level", int'(btn_level), 0);
        check("reset_pulses", int'({press_pulse, short_pulse, long_pulse, repeat_pulse}), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #3;

        press_for(3);
        expect_counts("glitch3", 0, 0, 0, 0);

        press_for(4);
        expect_counts("min4", 1, 1, 0, 0);

        press_for(10);
        expect_counts("short10", 1, 1, 0, 0);

        press_for(20);
        expect_counts("coincident20", 1, 1, 0, 0);

        press_for(21);
        expect_counts("just_long21", 1, 0, 1, 0);

        press_for(50);
`ifdef BTN_AUTOREPEAT_EN
        expect_counts("long50", 1, 0, 1, 3);
        check("long50_repeat_delay", t_rep - t_long, RP);
`else
        expect_counts("long50", 1, 0, 1, 0);
`endif
        check("long50_long_delay", t_long - t_press, LG);

        // Reset while held with hold count 10; the button then re-debounces.
        clear_counts();
        btn_n = 1'b0;
        repeat (16) @(posedge clk);
        #3;
        check("midhold_held", int'(btn_level), 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (press_pulse) found = i;
        end
        check("rst_repress_delay", found, 6);
        #2;
        btn_n = 1'b1;
        repeat (30) @(posedge clk);
        #3;
        expect_counts("midhold", 2, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
